// File: rtl/dmem_dump_streamer.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_dump_streamer
//  Purpose  : Sweeps a contiguous window of data memory through its
//             synchronous read port and emits each word with its address on
//             a valid/ready stream. Used after a program run while the CPU is
//             halted, to check results or upload memory to a host.
//  Ports    : clk_CPU, rst_n (async, active-low)
//             start, base_addr, word_count      - dump request
//             mem_rd_en, mem_addr, mem_rdata    - data memory read port
//             out_valid, out_ready, out_data,
//             out_addr, out_last                - output stream
//             busy, done                        - status
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_dump_streamer #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_CPU,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   word_count,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_WIDTH:0]   C_REM_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] C_ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_WAIT = 3'd2,
    S_SEND = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t                  state_q,     state_d;
  logic [ADDR_WIDTH-1:0]   cur_addr_q,  cur_addr_d;
  // One bit wider than the address so a full-memory dump can be counted.
  logic [ADDR_WIDTH:0]     remaining_q, remaining_d;
  logic [DATA_WIDTH-1:0]   out_data_q,  out_data_d;
  logic [ADDR_WIDTH-1:0]   out_addr_q,  out_addr_d;
  logic                    out_last_q,  out_last_d;

  always_ff @(posedge clk_CPU or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      out_last_q  <= out_last_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    out_last_d  = out_last_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (word_count != '0) begin
            cur_addr_d  = base_addr;
            remaining_d = word_count;
            state_d     = S_READ;
          end else begin
            // Empty window: report completion without touching memory.
            state_d = S_DONE;
          end
        end
      end
      S_READ: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Read data from the READ cycle is on mem_rdata now.
        out_data_d = mem_rdata;
        out_addr_d = cur_addr_q;
        out_last_d = (remaining_q == C_REM_ONE);
        state_d    = S_SEND;
      end
      S_SEND: begin
        if (out_ready) begin
          out_last_d  = 1'b0;
          remaining_d = remaining_q - C_REM_ONE;
          if (remaining_q == C_REM_ONE) begin
            state_d = S_DONE;
          end else begin
            // Natural wrap past the top of memory back to address 0.
            cur_addr_d = cur_addr_q + C_ADDR_ONE;
            state_d    = S_READ;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Address is forced to zero outside READ so it can be OR-ed onto a read
  // port shared with the CPU.
  assign mem_rd_en = (state_q == S_READ);
  assign mem_addr  = mem_rd_en ? cur_addr_q : '0;
  assign out_valid = (state_q == S_SEND);
  assign out_data  = out_data_q;
  assign out_addr  = out_addr_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q == S_READ) || (state_q == S_WAIT) || (state_q == S_SEND);
  assign done      = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_dmem_dump_streamer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_dump_streamer
//  Purpose  : Self-checking bench for dmem_dump_streamer. A model memory
//             feeds the read port; accepted dump requests are expanded into
//             expected beats (address, word, last flag) in a scoreboard queue
//             that a negedge monitor pops on every stream handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_dump_streamer;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int N  = 1 << AW;

  logic          clk_CPU = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   word_count;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata = '0;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_addr;
  logic          out_last;
  logic          busy;
  logic          done;

  dmem_dump_streamer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_CPU   (clk_CPU),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .word_count(word_count),
    .mem_rd_en (mem_rd_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_addr  (out_addr),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk_CPU = ~clk_CPU;

  // Data memory with a synchronous read port.
  logic [DW-1:0] mem [N];
  always @(posedge clk_CPU) if (mem_rd_en) mem_rdata <= mem[mem_addr];

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  beat_t exp_q[$];
  int    checks   = 0;
  int    failures = 0;
  int    cyc      = 0;
  int    ev_cyc   = -100;
  int    rd_cnt   = 0;
  int    exp_rd   = 0;
  bit    done_due = 0;
  bit    held_v   = 0;
  bit    prev_valid = 0;
  beat_t held;
  int    rdy_mode = 0;  // 0: always ready, 1: random, 2: driven by the test

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(posedge clk_CPU) begin
    #1;
    if (rdy_mode == 0)      out_ready = 1'b1;
    else if (rdy_mode == 1) out_ready = 1'($urandom_range(0, 1));
  end

  // Monitor / scoreboard.
  always @(negedge clk_CPU) begin
    beat_t e;
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      done_due   = 0;
      rd_cnt     = 0;
      exp_rd     = 0;
      held_v     = 0;
      prev_valid = 0;
      ev_cyc     = -100;
    end else begin
      chk("done_pulse", 64'(done), 64'(done_due));
      done_due = 0;
      if (mem_rd_en) rd_cnt++;

      if (held_v) begin
        chk("hold_valid", 64'(out_valid), 64'(1));
        chk("hold_beat", 64'({out_addr, out_data, out_last}), 64'(held));
      end
      if (out_valid && !prev_valid) chk("beat_latency", 64'(cyc), 64'(ev_cyc + 3));

      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 64'(out_valid), 64'(0));
        end else begin
          e = exp_q.pop_front();
          chk("beat_addr", 64'(out_addr), 64'(e.a));
          chk("beat_data", 64'(out_data), 64'(e.d));
          chk("beat_last", 64'(out_last), 64'(e.l));
          if (e.l) begin
            done_due = 1;
            chk("reads_per_dump", 64'(rd_cnt), 64'(exp_rd));
          end
        end
        ev_cyc = cyc;
        held_v = 0;
      end else if (out_valid) begin
        held_v = 1;
        held   = {out_addr, out_data, out_last};
      end else begin
        held_v = 0;
      end
      prev_valid = out_valid;

      // Request accepted only in IDLE (not busy, not in the done cycle).
      if (start && !busy && !done) begin
        if (word_count == '0) begin
          done_due = 1;
        end else begin
          for (int i = 0; i < int'(word_count); i++) begin
            logic [AW-1:0] a;
            a = AW'((int'(base_addr) + i) % N);
            exp_q.push_back({a, mem[a], (i == int'(word_count) - 1)});
          end
        end
        ev_cyc = cyc;
        rd_cnt = 0;
        exp_rd = int'(word_count);
      end
    end
  end

  task automatic do_start(input int b, input int c);
    @(posedge clk_CPU); #1;
    base_addr  = AW'(b);
    word_count = (AW+1)'(c);
    start      = 1'b1;
    @(posedge clk_CPU); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk_CPU); #1;
      if (!busy && !done && !out_valid && exp_q.size() == 0) return;
    end
    chk("timeout_pending_beats", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic wait_rd(input int n);
    int seen = 0;
    for (int i = 0; i < 200 && seen < n; i++) begin
      @(negedge clk_CPU);
      if (mem_rd_en) seen++;
    end
    chk("wait_rd_reached", 64'(seen), 64'(n));
  endtask

  initial begin
    start = 0; base_addr = '0; word_count = '0; out_ready = 1'b1;
    for (int i = 0; i < N; i++) mem[i] = ($urandom() & 32'hFFFF_FF00) | 32'(i);
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;

    rst_n = 1'b0;
    #1;
    chk("rst_mem_rd_en", 64'(mem_rd_en), 64'(0));
    chk("rst_mem_addr",  64'(mem_addr),  64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_data",  64'(out_data),  64'(0));
    chk("rst_out_addr",  64'(out_addr),  64'(0));
    chk("rst_out_last",  64'(out_last),  64'(0));
    chk("rst_busy",      64'(busy),      64'(0));
    chk("rst_done",      64'(done),      64'(0));
    repeat (3) @(posedge clk_CPU);
    @(negedge clk_CPU); #1 rst_n = 1'b1;

    // Basic 4-word dump, sink always ready.
    rdy_mode = 0;
    do_start(0, 4);
    wait_idle();

    // Same dump, sink stalls 5 cycles on the third word (addr 2).
    rdy_mode = 2; out_ready = 1'b1;
    do_start(0, 4);
    wait_rd(3);
    @(posedge clk_CPU); #1 out_ready = 1'b0;
    repeat (6) @(posedge clk_CPU);
    #1 out_ready = 1'b1;
    wait_idle();

    // Window wrapping past the top of memory.
    rdy_mode = 0;
    do_start(254, 4);
    wait_idle();

    // Empty window: done only, nothing else moves.
    do_start(7, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_CPU); #1;
      chk("empty_busy", 64'(busy), 64'(0));
      chk("empty_rd_en", 64'(mem_rd_en), 64'(0));
      chk("empty_valid", 64'(out_valid), 64'(0));
    end
    wait_idle();

    // A second start while streaming is ignored.
    do_start(40, 4);
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk_CPU);
    do_start(100, 3);
    wait_idle();

    // Randomized dumps with a random sink.
    rdy_mode = 1;
    for (int k = 0; k < 14; k++) begin
      int c;
      c = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 8));
      do_start(int'($urandom_range(0, N - 1)), c);
      wait_idle();
    end

    // Whole memory exactly once.
    do_start(int'($urandom_range(0, N - 1)), N);
    wait_idle();

    // Async reset mid-WAIT of the second word.
    rdy_mode = 0;
    do_start(0, 4);
    wait_rd(2);
    @(posedge clk_CPU); #2 rst_n = 1'b0;
    #1;
    chk("abort_busy",  64'(busy),      64'(0));
    chk("abort_valid", 64'(out_valid), 64'(0));
    chk("abort_rd_en", 64'(mem_rd_en), 64'(0));
    chk("abort_done",  64'(done),      64'(0));
    repeat (2) @(posedge clk_CPU);
    @(negedge clk_CPU); #1 rst_n = 1'b1;
    do_start(8, 1);
    wait_idle();

    // Async reset while a beat is stalled in SEND.
    rdy_mode = 2; out_ready = 1'b0;
    do_start(5, 2);
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk_CPU);
    chk("send_reached", 64'(out_valid), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("abort_send_valid", 64'(out_valid), 64'(0));
    chk("abort_send_busy",  64'(busy),      64'(0));
    repeat (2) @(posedge clk_CPU);
    @(negedge clk_CPU); #1 rst_n = 1'b1;
    out_ready = 1'b1; rdy_mode = 0;
    do_start(250, 3);
    wait_idle();

    repeat (3) @(negedge clk_CPU);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_dump_streamer.md
Name: dmem_dump_streamer

Overview:
- Read-side counterpart to the bench-time memory preload of the single-cycle MIPS datapath.
- After a program run, it sweeps a contiguous window of data memory through the memory's synchronous read port.
- Each word is emitted with its address on a valid/ready output stream, for result checking or host upload.
- Sits beside the data memory, sharing its read port while the CPU is halted.

Parameters:
- ADDR_WIDTH, 8, word-address width of the data memory (depth 2^ADDR_WIDTH words)
- DATA_WIDTH, 32, memory word width

Ports:
- clk_CPU  input  1  system clock; all logic on the rising edge
- rst_n  input  1  reset, asynchronous and active-low
- start  input  1  one-cycle request to begin a dump; sampled only in IDLE
- base_addr  input  ADDR_WIDTH  first word address; latched on accepted start
- word_count  input  ADDR_WIDTH+1  number of words, 0 to 2^ADDR_WIDTH; latched on accepted start
- mem_rd_en  output  1  read strobe to data memory
- mem_addr  output  ADDR_WIDTH  word address to data memory
- mem_rdata  input  DATA_WIDTH  memory read data, valid one cycle after mem_rd_en
- out_valid  output  1  stream word valid
- out_ready  input  1  stream sink ready
- out_data  output  DATA_WIDTH  stream word
- out_addr  output  ADDR_WIDTH  address the word was read from
- out_last  output  1  marks the final word of the dump; qualified by out_valid
- busy  output  1  dump in progress
- done  output  1  one-cycle pulse at dump completion

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE immediately.
  - All outputs go to 0: mem_rd_en, mem_addr, out_valid, out_data, out_addr, out_last, busy, done.
  - Internal address and remaining counters clear.
  - Reset mid-dump aborts the dump with no done pulse. The partially sent stream is abandoned.
- FSM states: IDLE, READ, WAIT, SEND, DONE.
- IDLE:
  - busy=0.
  - start=1 with word_count!=0: latch base_addr into cur_addr and word_count into remaining; go to READ.
  - start=1 with word_count==0: go to DONE. No memory access, no stream beat.
- READ:
  - busy=1, mem_rd_en=1, mem_addr=cur_addr for exactly this cycle; go to WAIT.
- WAIT:
  - mem_rd_en=0; mem_rdata is valid this cycle.
  - On the clock edge, register mem_rdata into out_data and cur_addr into out_addr.
  - Set out_last=(remaining==1) and out_valid=1; go to SEND.
- SEND:
  - out_valid=1; out_data, out_addr and out_last are held stable until the handshake.
  - Handshake occurs on an edge where out_valid and out_ready are both 1.
  - On handshake with remaining==1: out_valid=0; go to DONE.
  - On handshake with remaining>1: cur_addr increments, remaining decrements, out_valid=0; go to READ.
  - Without a handshake: stay in SEND.
- DONE:
  - done=1 for exactly one cycle, busy=0, out_last=0; go to IDLE.
- Throughput:
  - With out_ready held at 1, one word per 3 cycles.
  - First out_valid appears 3 edges after the edge that accepted start (IDLE→READ→WAIT→SEND).
  - No overlap of reads with the output beat.
- Address arithmetic:
  - cur_addr increments modulo 2^ADDR_WIDTH; the window wraps past the top of memory back to 0.
  - word_count=2^ADDR_WIDTH dumps the entire memory exactly once.
- start is ignored in every state other than IDLE, including DONE.
- out_ready is ignored unless out_valid=1.
- mem_rdata is sampled only in WAIT.

Test Plan:
- Preload dataMemory[0..3]=0x11,0x22,0x33,0x44; base=0, count=4, out_ready=1 → 4 beats (addr 0..3, data 0x11..0x44), out_last only on addr 3; beats 3 cycles apart; done pulses the cycle after the 4th handshake.
- Same dump with out_ready low for 5 cycles on beat 2 → out_valid, out_data=0x33 and out_addr=2 held steady throughout; exactly one mem_rd_en per word; no duplicate or lost words.
- base=254, count=4, ADDR_WIDTH=8 → out_addr sequence 254, 255, 0, 1 with the matching memory data; out_last on addr 1.
- count=0 with start → no mem_rd_en, no out_valid, done=1 exactly one cycle after start; busy stays 0.
- start pulsed again during SEND of a 4-word dump → ignored; exactly 4 beats and one done pulse result.
- rst_n driven low asynchronously mid-WAIT of word 2 → out_valid, busy and mem_rd_en drop without waiting for a clock; no done pulse. After release, a new start with base=8, count=1 produces a single beat at addr 8 with out_last=1.
